// File: rtl/nrisc_pkg.sv
// nrisc_pkg
// Shared definitions for the NRISC execute-to-writeback path.
//   TAM, RADDR    : ULA data width and register-file address width
//   FLAG_*        : bit positions inside the 3-bit ULA flag vector {F2, Z, C}
//   br_cond_e     : branch condition encodings COND_AL..COND_NV
//   wb_entry_t    : one buffered register-file write {addr, data}
//   eval_cond()   : evaluates a branch condition against a flag vector
package nrisc_pkg;

  localparam int TAM   = 16;
  localparam int RADDR = 4;

  localparam int FLAG_C  = 0;
  localparam int FLAG_Z  = 1;
  localparam int FLAG_F2 = 2;

  typedef enum logic [2:0] {
    COND_AL  = 3'b000,
    COND_Z   = 3'b001,
    COND_NZ  = 3'b010,
    COND_C   = 3'b011,
    COND_NC  = 3'b100,
    COND_F2  = 3'b101,
    COND_NF2 = 3'b110,
    COND_NV  = 3'b111
  } br_cond_e;

  typedef struct packed {
    logic [RADDR-1:0] addr;
    logic [TAM-1:0]   data;
  } wb_entry_t;

  // COND_NV falls into the default arm and is never taken.
  function automatic logic eval_cond(input logic [2:0] cond, input logic [2:0] f);
    logic r;
    r = 1'b0;
    case (br_cond_e'(cond))
      COND_AL:  r = 1'b1;
      COND_Z:   r = f[FLAG_Z];
      COND_NZ:  r = ~f[FLAG_Z];
      COND_C:   r = f[FLAG_C];
      COND_NC:  r = ~f[FLAG_C];
      COND_F2:  r = f[FLAG_F2];
      COND_NF2: r = ~f[FLAG_F2];
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nrisc_ula_result_stage_if.sv
// nrisc_ula_result_stage_if
// Bundles the ULA-side input handshake and the register-file write-back
// handshake of the result stage.
//   in_valid/in_ready, ula_out, ula_flags, in_dest, in_wr_en, in_flag_we : ULA side
//   wb_valid/wb_ready, wb_data, wb_addr                                  : register-file side
// Modports:
//   slave  : the result stage (consumes ULA results, produces write-backs)
//   master : the surrounding pipeline (ULA producer and register-file consumer)
interface nrisc_ula_result_stage_if;
  import nrisc_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [TAM-1:0]   ula_out;
  logic [2:0]       ula_flags;
  logic [RADDR-1:0] in_dest;
  logic             in_wr_en;
  logic             in_flag_we;

  logic             wb_valid;
  logic             wb_ready;
  logic [TAM-1:0]   wb_data;
  logic [RADDR-1:0] wb_addr;

  modport slave (
    input  in_valid, ula_out, ula_flags, in_dest, in_wr_en, in_flag_we, wb_ready,
    output in_ready, wb_valid, wb_data, wb_addr
  );

  modport master (
    output in_valid, ula_out, ula_flags, in_dest, in_wr_en, in_flag_we, wb_ready,
    input  in_ready, wb_valid, wb_data, wb_addr
  );

endinterface

// File: rtl/nrisc_result_fifo.sv
// nrisc_result_fifo
// DEPTH-entry FIFO of pending register-file writes.
// Parameters: DEPTH (power of two, >= 2)
// Ports:
//   clk, rst    : clock, synchronous active-high reset (empties FIFO, clears storage)
//   push        : write push_entry at the tail (ignored when full)
//   push_entry  : {addr, data} to store
//   pop         : drop the head entry (ignored when empty)
//   head_entry  : current head, read combinationally from storage
//   full, empty : occupancy flags derived from the registered count
module nrisc_result_fifo
  import nrisc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head_entry,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign head_entry = mem[rd_ptr];
  assign push_ok    = push & ~full;
  assign pop_ok     = pop & ~empty;

  // Storage is cleared on reset so the head reads as zero until the first write.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nrisc_ula_result_stage.sv
// nrisc_ula_result_stage
// Execute-to-writeback stage behind the NRISC ULA. Accepted results that write the
// register file are buffered in nrisc_result_fifo; results that update flags load
// the architectural flag register; branch queries are answered one cycle later.
// Parameters: DEPTH (result FIFO depth, power of two, >= 2). Data/address widths
//   come from nrisc_pkg (TAM, RADDR) so the interface and the stage always agree.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : ULA input handshake and register-file write-back handshake
//   flags_q           : architectural flag register {F2, Z, C}
//   br_req, br_cond   : branch condition query
//   br_valid, br_taken: registered answer, valid the cycle after br_req
// Build option: NRISC_FLAG_FWD_EN forwards the incoming ula_flags to a branch
//   evaluated in the same cycle as a flag-setting result; without it the branch
//   sees the flag register value from before that result.
module nrisc_ula_result_stage
  import nrisc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  nrisc_ula_result_stage_if.slave    bus,
  output logic [2:0]                 flags_q,
  input  logic                       br_req,
  input  logic [2:0]                 br_cond,
  output logic                       br_valid,
  output logic                       br_taken
);

  logic      accept;
  logic      push;
  logic      pop;
  logic      fifo_full;
  logic      fifo_empty;
  wb_entry_t push_entry;
  wb_entry_t head_entry;
  logic [2:0] flags_eval;

  // in_ready depends only on the registered count, never on wb_ready, so a full
  // FIFO does not let a result slip through even if the head is leaving.
  assign bus.in_ready = ~rst & ~fifo_full;
  assign accept       = bus.in_valid & bus.in_ready;
  assign push         = accept & bus.in_wr_en;
  assign pop          = bus.wb_valid & bus.wb_ready;
  assign push_entry   = '{addr: bus.in_dest, data: bus.ula_out};

  assign bus.wb_valid = ~fifo_empty;
  assign bus.wb_data  = head_entry.data;
  assign bus.wb_addr  = head_entry.addr;

  nrisc_result_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Flag register only moves on an accepted flag-setting instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 3'b000;
    end else if (accept && bus.in_flag_we) begin
      flags_q <= bus.ula_flags;
    end
  end

`ifdef NRISC_FLAG_FWD_EN
  assign flags_eval = (accept && bus.in_flag_we) ? bus.ula_flags : flags_q;
`else
  assign flags_eval = flags_q;
`endif

  // br_taken is forced low whenever no query was made.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_valid <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      br_valid <= br_req;
      br_taken <= br_req & eval_cond(br_cond, flags_eval);
    end
  end

endmodule

// File: tb/tb_nrisc_ula_result_stage.sv
// tb_nrisc_ula_result_stage
// Directed bench for nrisc_ula_result_stage. Expected write-backs and branch answers
// are queued when stimulus is issued; a negedge monitor pops and compares them
// whenever the stage presents a write-back or a branch answer.
module tb_nrisc_ula_result_stage;
  import nrisc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] flags_q;
  logic       br_req;
  logic [2:0] br_cond;
  logic       br_valid;
  logic       br_taken;

  nrisc_ula_result_stage_if bus ();

  nrisc_ula_result_stage #(
    .DEPTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flags_q  (flags_q),
    .br_req   (br_req),
    .br_cond  (br_cond),
    .br_valid (br_valid),
    .br_taken (br_taken)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  bit         mon_en = 1'b0;
  wb_entry_t  wb_exp_q[$];
  logic       br_exp_q[$];
  logic [2:0] model_flags;
  wb_entry_t  mon_e;
  logic       mon_b;

`ifdef NRISC_FLAG_FWD_EN
  localparam logic FWD_TAKEN = 1'b1;
`else
  localparam logic FWD_TAKEN = 1'b0;
`endif

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one cycle of stimulus, queues the expected effects and checks flags_q.
  task automatic applyStimulus(input logic valid, input logic [TAM-1:0] data,
                               input logic [2:0] flg, input logic [RADDR-1:0] dest,
                               input logic wr, input logic fwe, input logic breq,
                               input logic [2:0] cond, input logic exp_accept,
                               input logic exp_taken);
    bus.in_valid   = valid;
    bus.ula_out    = data;
    bus.ula_flags  = flg;
    bus.in_dest    = dest;
    bus.in_wr_en   = wr;
    bus.in_flag_we = fwe;
    br_req         = breq;
    br_cond        = cond;
    if (valid) checkOutput("in_ready", bus.in_ready, exp_accept);
    if (valid && exp_accept && wr) wb_exp_q.push_back('{addr: dest, data: data});
    if (breq) br_exp_q.push_back(exp_taken);
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.in_wr_en   = 1'b0;
    bus.in_flag_we = 1'b0;
    br_req         = 1'b0;
    if (valid && exp_accept && fwe) model_flags = flg;
    checkOutput("flags_q", flags_q, model_flags);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.wb_valid) begin
        if (wb_exp_q.size() == 0) begin
          checkOutput("wb_valid_unexpected", bus.wb_valid, 1'b0);
        end else if (bus.wb_ready) begin
          mon_e = wb_exp_q.pop_front();
          checkOutput("wb_data", bus.wb_data, mon_e.data);
          checkOutput("wb_addr", bus.wb_addr, mon_e.addr);
        end
      end
      if (br_valid) begin
        if (br_exp_q.size() == 0) begin
          checkOutput("br_valid_unexpected", br_valid, 1'b0);
        end else begin
          mon_b = br_exp_q.pop_front();
          checkOutput("br_taken", br_taken, mon_b);
        end
      end else begin
        checkOutput("br_taken_idle", br_taken, 1'b0);
      end
    end
  end

  logic [7:0] br_tab;

  initial begin
    // Test 1: reset held two cycles with a write-and-flag result offered.
    rst            = 1'b1;
    bus.in_valid   = 1'b1;
    bus.ula_out    = 16'hABCD;
    bus.ula_flags  = 3'b111;
    bus.in_dest    = 4'd9;
    bus.in_wr_en   = 1'b1;
    bus.in_flag_we = 1'b1;
    bus.wb_ready   = 1'b1;
    br_req         = 1'b0;
    br_cond        = 3'b000;
    model_flags    = 3'b000;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", bus.in_ready, 1'b0);
    checkOutput("rst_wb_valid", bus.wb_valid, 1'b0);
    checkOutput("rst_wb_data", bus.wb_data, 16'h0000);
    checkOutput("rst_wb_addr", bus.wb_addr, 4'd0);
    checkOutput("rst_flags_q", flags_q, 3'b000);
    checkOutput("rst_br_valid", br_valid, 1'b0);
    checkOutput("rst_br_taken", br_taken, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rst2_in_ready", bus.in_ready, 1'b0);
    checkOutput("rst2_wb_valid", bus.wb_valid, 1'b0);
    checkOutput("rst2_flags_q", flags_q, 3'b000);
    rst            = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_wr_en   = 1'b0;
    bus.in_flag_we = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", bus.in_ready, 1'b1);
    mon_en = 1'b1;

    // Test 2: single write with flag update, sink ready.
    applyStimulus(1, 16'hFFFF, 3'b100, 4'd3, 1, 1, 0, 3'b000, 1, 0);
    checkOutput("wb_valid_latency", bus.wb_valid, 1'b1);
    idle(1);
    checkOutput("wb_valid_drained", bus.wb_valid, 1'b0);

    // Test 3: fill under backpressure, overflow attempt, then drain in order.
    bus.wb_ready = 1'b0;
    applyStimulus(1, 16'h5555, 3'b000, 4'd1, 1, 0, 0, 3'b000, 1, 0);
    applyStimulus(1, 16'h0000, 3'b000, 4'd2, 1, 0, 0, 3'b000, 1, 0);
    checkOutput("full_in_ready", bus.in_ready, 1'b0);
    applyStimulus(1, 16'h1234, 3'b000, 4'd5, 1, 0, 0, 3'b000, 0, 0);
    bus.wb_ready = 1'b1;
    idle(3);
    checkOutput("drained_wb_valid", bus.wb_valid, 1'b0);

    // Accepted result with neither write nor flag update is dropped.
    applyStimulus(1, 16'h7777, 3'b011, 4'd8, 0, 0, 0, 3'b000, 1, 0);
    idle(1);

    // Test 4: flag-setting result and Z-branch in the same cycle (old flags 100).
    applyStimulus(1, 16'h0000, 3'b010, 4'd0, 0, 1, 1, 3'b001, 1, FWD_TAKEN);
    idle(1);

    // Test 5: flags 001, every condition back to back.
    // Index = condition code: AL1 Z0 NZ1 C1 NC0 F2:0 NF2:1 NV0.
    applyStimulus(1, 16'h0000, 3'b001, 4'd0, 0, 1, 0, 3'b000, 1, 0);
    br_tab = 8'b0100_1101;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(0, 16'h0000, 3'b000, 4'd0, 0, 0, 1, 3'(c), 0, br_tab[c]);
    end
    idle(2);
    checkOutput("br_valid_idle", br_valid, 1'b0);

    // Test 6: full FIFO, reset one cycle mid-drain.
    bus.wb_ready = 1'b0;
    applyStimulus(1, 16'hA5A5, 3'b000, 4'd6, 1, 0, 0, 3'b000, 1, 0);
    applyStimulus(1, 16'h5A5A, 3'b000, 4'd7, 1, 0, 0, 3'b000, 1, 0);
    checkOutput("full2_in_ready", bus.in_ready, 1'b0);
    bus.wb_ready = 1'b1;
    idle(1);
    rst          = 1'b1;
    bus.wb_ready = 1'b0;
    idle(1);
    checkOutput("midrst_wb_valid", bus.wb_valid, 1'b0);
    checkOutput("midrst_flags_q", flags_q, 3'b000);
    wb_exp_q.delete();
    model_flags  = 3'b000;
    rst          = 1'b0;
    bus.wb_ready = 1'b1;
    idle(4);
    checkOutput("after_rst_wb_valid", bus.wb_valid, 1'b0);
    checkOutput("after_rst_in_ready", bus.in_ready, 1'b1);

    checkOutput("wb_queue_left", wb_exp_q.size(), 0);
    checkOutput("br_queue_left", br_exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
